// File: rtl/branch_flag_unit_pkg.sv
// Shared encodings for the branch/flag unit: ALU opcode classes, branch
// condition codes and the flush state machine encoding.
package branch_flag_unit_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_SLL = 3'b011;
    localparam logic [2:0] OP_SRL = 3'b100;
    localparam logic [2:0] OP_SRA = 3'b101;
    localparam logic [2:0] OP_LL  = 3'b110;
    localparam logic [2:0] OP_LH  = 3'b111;

    localparam logic [2:0] COND_NE = 3'b000;
    localparam logic [2:0] COND_EQ = 3'b001;
    localparam logic [2:0] COND_GT = 3'b010;
    localparam logic [2:0] COND_LT = 3'b011;
    localparam logic [2:0] COND_GE = 3'b100;
    localparam logic [2:0] COND_LE = 3'b101;
    localparam logic [2:0] COND_OV = 3'b110;
    localparam logic [2:0] COND_UN = 3'b111;

    localparam int CNT_W = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    function automatic logic op_writes_ov(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    function automatic logic op_writes_zn(input logic [2:0] op);
        return (op != OP_LL) && (op != OP_LH);
    endfunction

endpackage

// File: rtl/branch_flag_unit_cond_eval.sv
// Pure combinational branch condition evaluator over a Z/OV/N flag triple.
module cond_eval
    import branch_flag_unit_pkg::*;
(
    input  logic       eff_z,
    input  logic       eff_ov,
    input  logic       eff_n,
    input  logic [2:0] cond,
    output logic       taken
);

    always_comb begin
        case (cond)
            COND_NE: taken = !eff_z;
            COND_EQ: taken = eff_z;
            COND_GT: taken = !eff_z && !eff_n;
            COND_LT: taken = eff_n;
            COND_GE: taken = eff_z || !eff_n;
            COND_LE: taken = eff_n || eff_z;
            COND_OV: taken = eff_ov;
            default: taken = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_flag_unit.sv
// Execute-stage flag register and branch resolver: forwards same-cycle ALU
// flags into branch decisions and issues a registered redirect plus flush.
module branch_flag_unit
    import branch_flag_unit_pkg::*;
#(
    parameter int PC_W         = 16,
    parameter int OFF_W        = 9,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alu_valid,
    input  logic [2:0]       alu_opcode,
    input  logic             alu_z,
    input  logic             alu_ov,
    input  logic             alu_n,
    input  logic             br_valid,
    input  logic [2:0]       br_cond,
    input  logic [PC_W-1:0]  br_pc,
    input  logic [OFF_W-1:0] br_offset,
    output logic             flag_z,
    output logic             flag_ov,
    output logic             flag_n,
    output logic             redirect_valid,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             flush,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flag_z_q, flag_z_d;
    logic             flag_ov_q, flag_ov_d;
    logic             flag_n_q, flag_n_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic [PC_W-1:0]  redirect_pc_q, redirect_pc_d;
    logic             flush_q, flush_d;
    logic             busy_q, busy_d;

    logic             upd_zn, upd_ov, taken;
    logic [PC_W-1:0]  offset_ext, target;

    // Everything arriving while a flush is in progress belongs to squashed instructions.
    assign upd_zn = alu_valid && (state_q == ST_IDLE) && op_writes_zn(alu_opcode);
    assign upd_ov = alu_valid && (state_q == ST_IDLE) && op_writes_ov(alu_opcode);

    assign flag_z_d  = upd_zn ? alu_z  : flag_z_q;
    assign flag_ov_d = upd_ov ? alu_ov : flag_ov_q;
    assign flag_n_d  = upd_zn ? alu_n  : flag_n_q;

    assign offset_ext = {{(PC_W-OFF_W){br_offset[OFF_W-1]}}, br_offset};
    assign target     = br_pc + PC_W'(1) + offset_ext;

    cond_eval u_cond_eval (
        .eff_z  (flag_z_d),
        .eff_ov (flag_ov_d),
        .eff_n  (flag_n_d),
        .cond   (br_cond),
        .taken  (taken)
    );

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        flush_d          = flush_q;
        busy_d           = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (br_valid && taken) begin
                    state_d          = ST_FLUSH;
                    cnt_d            = CNT_W'(FLUSH_CYCLES - 1);
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = target;
                    flush_d          = 1'b1;
                    busy_d           = 1'b1;
                end
            end
            default: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ST_IDLE;
                    flush_d = 1'b0;
                    busy_d  = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            cnt_q            <= '0;
            flag_z_q         <= 1'b0;
            flag_ov_q        <= 1'b0;
            flag_n_q         <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            flush_q          <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            flag_z_q         <= flag_z_d;
            flag_ov_q        <= flag_ov_d;
            flag_n_q         <= flag_n_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            flush_q          <= flush_d;
            busy_q           <= busy_d;
        end
    end

    assign flag_z         = flag_z_q;
    assign flag_ov        = flag_ov_q;
    assign flag_n         = flag_n_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush          = flush_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_branch_flag_unit.sv
// Directed, table-driven bench for branch_flag_unit with hand sequences for
// flush squashing and reset during a flush.
module tb_branch_flag_unit;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic [2:0]  alu_opcode;
    logic        alu_z, alu_ov, alu_n;
    logic        br_valid;
    logic [2:0]  br_cond;
    logic [15:0] br_pc;
    logic [8:0]  br_offset;
    logic        flag_z, flag_ov, flag_n;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        flush;
    logic        busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        alu_valid;
        logic [2:0]  op;
        logic        z, ov, n;
        logic        br_valid;
        logic [2:0]  cond;
        logic [15:0] pc;
        logic [8:0]  off;
        logic [2:0]  exp_flags;
        logic        exp_rv;
        logic [15:0] exp_pc;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs[NVEC];

    branch_flag_unit #(.PC_W(16), .OFF_W(9), .FLUSH_CYCLES(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .alu_valid      (alu_valid),
        .alu_opcode     (alu_opcode),
        .alu_z          (alu_z),
        .alu_ov         (alu_ov),
        .alu_n          (alu_n),
        .br_valid       (br_valid),
        .br_cond        (br_cond),
        .br_pc          (br_pc),
        .br_offset      (br_offset),
        .flag_z         (flag_z),
        .flag_ov        (flag_ov),
        .flag_n         (flag_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .busy           (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic av, input logic [2:0] op, input logic z, input logic ov,
                                input logic n, input logic bv, input logic [2:0] cond,
                                input logic [15:0] pc, input logic [8:0] off,
                                input logic [2:0] ef, input logic erv, input logic [15:0] epc);
        vec_t v;
        v.alu_valid = av; v.op = op; v.z = z; v.ov = ov; v.n = n;
        v.br_valid = bv; v.cond = cond; v.pc = pc; v.off = off;
        v.exp_flags = ef; v.exp_rv = erv; v.exp_pc = epc;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clearInputs();
        alu_valid = 1'b0; alu_opcode = 3'b000; alu_z = 1'b0; alu_ov = 1'b0; alu_n = 1'b0;
        br_valid = 1'b0; br_cond = 3'b000; br_pc = 16'h0; br_offset = 9'h0;
    endtask

    // Drive one vector for exactly one rising edge, then sample just after it.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        alu_valid = v.alu_valid; alu_opcode = v.op;
        alu_z = v.z; alu_ov = v.ov; alu_n = v.n;
        br_valid = v.br_valid; br_cond = v.cond; br_pc = v.pc; br_offset = v.off;
        @(posedge clk);
        #1;
        clearInputs();
    endtask

    task automatic drainFlush(input string name);
        int cyc = 0;
        while (flush === 1'b1 && cyc < 20) begin
            cyc++;
            @(posedge clk);
            #1;
        end
        checkOutput({name, "_flush_len"}, 32'(cyc), 32'd2);
        checkOutput({name, "_busy_end"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        // add/sub/xor/sll/srl/sra/ll/lh = 0..7; NE EQ GT LT GE LE OV UN = 0..7
        vecs[0]  = mk(1, 3'd0, 0, 1, 1, 0, 3'd0, 16'h0000, 9'h000, 3'b011, 0, 16'h0000);
        vecs[1]  = mk(1, 3'd2, 1, 0, 0, 0, 3'd0, 16'h0000, 9'h000, 3'b110, 0, 16'h0000);
        vecs[2]  = mk(1, 3'd6, 0, 0, 1, 0, 3'd0, 16'h0000, 9'h000, 3'b110, 0, 16'h0000);
        vecs[3]  = mk(0, 3'd0, 0, 0, 0, 1, 3'd1, 16'h0010, 9'h005, 3'b110, 1, 16'h0016);
        vecs[4]  = mk(1, 3'd1, 0, 0, 0, 0, 3'd0, 16'h0000, 9'h000, 3'b000, 0, 16'h0000);
        vecs[5]  = mk(1, 3'd1, 1, 0, 0, 1, 3'd1, 16'h0100, 9'h000, 3'b100, 1, 16'h0101);
        vecs[6]  = mk(0, 3'd0, 0, 0, 0, 1, 3'd0, 16'h0020, 9'h000, 3'b100, 0, 16'h0000);
        vecs[7]  = mk(0, 3'd0, 0, 0, 0, 1, 3'd7, 16'hFFFE, 9'h003, 3'b100, 1, 16'h0002);
        vecs[8]  = mk(0, 3'd0, 0, 0, 0, 1, 3'd7, 16'h0004, 9'h1F6, 3'b100, 1, 16'hFFFB);
        vecs[9]  = mk(1, 3'd0, 0, 1, 1, 0, 3'd0, 16'h0000, 9'h000, 3'b011, 0, 16'h0000);
        vecs[10] = mk(0, 3'd0, 0, 0, 0, 1, 3'd2, 16'h0030, 9'h000, 3'b011, 0, 16'h0000);
        vecs[11] = mk(0, 3'd0, 0, 0, 0, 1, 3'd3, 16'h0030, 9'h1FF, 3'b011, 1, 16'h0030);
        vecs[12] = mk(0, 3'd0, 0, 0, 0, 1, 3'd5, 16'h0040, 9'h002, 3'b011, 1, 16'h0043);
        vecs[13] = mk(0, 3'd0, 0, 0, 0, 1, 3'd6, 16'h0060, 9'h000, 3'b011, 1, 16'h0061);
        vecs[14] = mk(1, 3'd2, 0, 0, 0, 1, 3'd4, 16'h0050, 9'h000, 3'b010, 1, 16'h0051);
        vecs[15] = mk(1, 3'd1, 0, 0, 0, 1, 3'd6, 16'h0070, 9'h000, 3'b000, 0, 16'h0000);
        vecs[16] = mk(0, 3'd0, 0, 0, 0, 1, 3'd4, 16'h0080, 9'h1FE, 3'b000, 1, 16'h007F);
        vecs[17] = mk(1, 3'd4, 1, 1, 1, 1, 3'd2, 16'h0090, 9'h000, 3'b101, 0, 16'h0000);

        clearInputs();
        rst_n = 1'b0;
        #12;
        checkOutput("reset_flags", {29'b0, flag_z, flag_ov, flag_n}, 32'd0);
        checkOutput("reset_rv", {31'b0, redirect_valid}, 32'd0);
        checkOutput("reset_pc", {16'b0, redirect_pc}, 32'd0);
        checkOutput("reset_flush", {30'b0, flush, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("v%0d_flags", i), {29'b0, flag_z, flag_ov, flag_n}, {29'b0, vecs[i].exp_flags});
            checkOutput($sformatf("v%0d_rv", i), {31'b0, redirect_valid}, {31'b0, vecs[i].exp_rv});
            if (vecs[i].exp_rv) begin
                checkOutput($sformatf("v%0d_pc", i), {16'b0, redirect_pc}, {16'b0, vecs[i].exp_pc});
                checkOutput($sformatf("v%0d_busy", i), {31'b0, busy}, 32'd1);
                drainFlush($sformatf("v%0d", i));
            end else begin
                checkOutput($sformatf("v%0d_flush", i), {30'b0, flush, busy}, 32'd0);
            end
        end

        // Traffic arriving during a flush must be squashed; flags start at 101 here.
        @(negedge clk);
        br_valid = 1'b1; br_cond = 3'd7; br_pc = 16'h0200; br_offset = 9'h000;
        @(posedge clk);
        #1;
        checkOutput("sq_rv", {31'b0, redirect_valid}, 32'd1);
        checkOutput("sq_pc", {16'b0, redirect_pc}, 32'h0201);
        alu_valid = 1'b1; alu_opcode = 3'd0; alu_z = 1'b1; alu_ov = 1'b1; alu_n = 1'b1;
        br_pc = 16'h0400;
        @(posedge clk);
        #1;
        checkOutput("sq_rv_c2", {31'b0, redirect_valid}, 32'd0);
        checkOutput("sq_flags_c2", {29'b0, flag_z, flag_ov, flag_n}, 32'b101);
        checkOutput("sq_flush_c2", {31'b0, flush}, 32'd1);
        @(posedge clk);
        #1;
        clearInputs();
        checkOutput("sq_rv_c3", {31'b0, redirect_valid}, 32'd0);
        checkOutput("sq_flags_c3", {29'b0, flag_z, flag_ov, flag_n}, 32'b101);
        checkOutput("sq_flush_c3", {30'b0, flush, busy}, 32'd0);
        checkOutput("sq_pc_hold", {16'b0, redirect_pc}, 32'h0201);

        // Reset asserted during the first flush cycle.
        applyStimulus(mk(1, 3'd0, 1, 1, 1, 0, 3'd0, 16'h0, 9'h0, 3'b111, 0, 16'h0));
        checkOutput("rs_pre_flags", {29'b0, flag_z, flag_ov, flag_n}, 32'b111);
        applyStimulus(mk(0, 3'd0, 0, 0, 0, 1, 3'd7, 16'h0300, 9'h004, 3'b111, 1, 16'h0305));
        checkOutput("rs_pre_pc", {16'b0, redirect_pc}, 32'h0305);
        checkOutput("rs_pre_flush", {31'b0, flush}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rs_flush", {30'b0, flush, busy}, 32'd0);
        checkOutput("rs_rv", {31'b0, redirect_valid}, 32'd0);
        checkOutput("rs_pc", {16'b0, redirect_pc}, 32'd0);
        checkOutput("rs_flags", {29'b0, flag_z, flag_ov, flag_n}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rs_idle_rv", {31'b0, redirect_valid}, 32'd0);
        applyStimulus(mk(0, 3'd0, 0, 0, 0, 1, 3'd7, 16'h0010, 9'h001, 3'b000, 1, 16'h0012));
        checkOutput("post_rv", {31'b0, redirect_valid}, 32'd1);
        checkOutput("post_pc", {16'b0, redirect_pc}, 32'h0012);
        drainFlush("post");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
